// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared state and op encodings for the sequential adder/subtractor
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } op_t;

endpackage

// File: rtl/add_chunk.sv
// rtl/add_chunk.sv - combinational W-bit adder slice with carry in and carry out
module add_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - multi-cycle add/subtract, CHUNK bits per cycle, valid/ready on both sides
module seq_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_c,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_addsub: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   out_q;
    logic               out_c_q, out_overflow_q, out_zero_q;

    logic [CHUNK-1:0]   a_chunk, b_chunk, sum_chunk;
    logic               cout_chunk;
    logic [WIDTH-1:0]   out_next;
    logic               last_chunk;

    // b_q already holds the inverted operand for subtraction, so the slice only ever adds
    always_comb begin
        a_chunk  = '0;
        b_chunk  = '0;
        out_next = out_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IDX_W'(k)) begin
                a_chunk = a_q[k*CHUNK +: CHUNK];
                b_chunk = b_q[k*CHUNK +: CHUNK];
                out_next[k*CHUNK +: CHUNK] = sum_chunk;
            end
        end
    end

    add_chunk #(.W(CHUNK)) u_add_chunk (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry_q),
        .sum  (sum_chunk),
        .cout (cout_chunk)
    );

    assign last_chunk = (idx_q == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = CALC;
            CALC:    if (last_chunk) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q            <= '0;
            b_q            <= '0;
            idx_q          <= '0;
            carry_q        <= 1'b0;
            out_q          <= '0;
            out_c_q        <= 1'b0;
            out_overflow_q <= 1'b0;
            out_zero_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= (op_t'(sub) == SUB) ? ~b : b;
                        idx_q   <= '0;
                        carry_q <= sub;
                    end
                end
                CALC: begin
                    out_q   <= out_next;
                    carry_q <= cout_chunk;
                    idx_q   <= idx_q + IDX_W'(1);
                    if (last_chunk) begin
                        out_c_q        <= cout_chunk;
                        out_overflow_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                          (sum_chunk[CHUNK-1] != a_q[WIDTH-1]);
                        out_zero_q     <= (out_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out          = out_q;
    assign out_c        = out_c_q;
    assign out_overflow = out_overflow_q;
    assign out_zero     = out_zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// tb/tb_seq_addsub.sv - randomized self-checking bench for seq_addsub at CHUNK 8, 32 and 1
module tb_seq_addsub;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a   = '0;
    logic [31:0] b   = '0;
    logic        sub = 1'b0;

    logic        in_valid_v  [3];
    logic        out_ready_v [3];
    logic        in_ready_v  [3];
    logic        out_valid_v [3];
    logic [31:0] out_v       [3];
    logic        out_c_v     [3];
    logic        out_ovf_v   [3];
    logic        out_zero_v  [3];

    int checks = 0;
    int errors = 0;
    int lat_tab [3] = '{4, 1, 32};

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out(out_v[0]), .out_c(out_c_v[0]), .out_overflow(out_ovf_v[0]), .out_zero(out_zero_v[0])
    );

    seq_addsub #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out(out_v[1]), .out_c(out_c_v[1]), .out_overflow(out_ovf_v[1]), .out_zero(out_zero_v[1])
    );

    seq_addsub #(.WIDTH(32), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .out(out_v[2]), .out_c(out_c_v[2]), .out_overflow(out_ovf_v[2]), .out_zero(out_zero_v[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // returns {zero, overflow, carry, result} from plain integer arithmetic
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] r;
        logic        c;
        longint      f;
        logic        ov;
        if (s) begin
            r = x - y;
            c = (x >= y);
            f = longint'($signed(x)) - longint'($signed(y));
        end else begin
            {c, r} = {1'b0, x} + {1'b0, y};
            f = longint'($signed(x)) + longint'($signed(y));
        end
        ov = (f > 64'sd2147483647) || (f < -64'sd2147483648);
        return {(r == 32'd0), ov, c, r};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom % 6)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input int u, input logic [31:0] aa, input logic [31:0] bb,
                         input logic ss, input int hold);
        logic [34:0] m;
        int          lat;
        m = model(aa, bb, ss);
        @(negedge clk);
        a = aa; b = bb; sub = ss; in_valid_v[u] = 1'b1;
        check("in_ready_idle", 64'(in_ready_v[u]), 64'd1);
        @(posedge clk); #1;
        in_valid_v[u] = 1'b0;
        lat = 0;
        while (!out_valid_v[u] && lat < 100) begin
            a = $urandom; b = $urandom; sub = 1'($urandom); in_valid_v[u] = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        in_valid_v[u] = 1'b0;
        check("latency", 64'(lat), 64'(lat_tab[u]));
        check("out", 64'(out_v[u]), 64'(m[31:0]));
        check("out_c", 64'(out_c_v[u]), 64'(m[32]));
        check("out_overflow", 64'(out_ovf_v[u]), 64'(m[33]));
        check("out_zero", 64'(out_zero_v[u]), 64'(m[34]));
        for (int h = 0; h < hold; h++) begin
            in_valid_v[u] = 1'($urandom); a = $urandom; b = $urandom;
            @(posedge clk); #1;
            check("hold_valid", 64'(out_valid_v[u]), 64'd1);
            check("hold_in_ready", 64'(in_ready_v[u]), 64'd0);
            check("hold_fields", 64'({out_zero_v[u], out_ovf_v[u], out_c_v[u], out_v[u]}), 64'(m));
        end
        // in_valid stays high across the release edge: that must not start a new op
        in_valid_v[u] = 1'b1;
        out_ready_v[u] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[u] = 1'b0;
        in_valid_v[u] = 1'b0;
        check("release_valid", 64'(out_valid_v[u]), 64'd0);
        check("release_in_ready", 64'(in_ready_v[u]), 64'd1);
    endtask

    initial begin
        int rose;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i]  = 1'b0;
            out_ready_v[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_out_valid", 64'(out_valid_v[i]), 64'd0);
            check("rst_in_ready", 64'(in_ready_v[i]), 64'd1);
            check("rst_fields", 64'({out_zero_v[i], out_ovf_v[i], out_c_v[i], out_v[i]}), 64'd0);
        end
        rst = 1'b0;

        do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(0, 32'd5, 32'd7, 1'b1, 0);
        do_op(0, 32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        do_op(0, $urandom, $urandom, 1'($urandom), 5);
        do_op(1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 2);
        do_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 2);

        // abort an operation after two CALC edges
        @(negedge clk);
        a = 32'h1234_5678; b = 32'h0F0F_0F0F; sub = 1'b0; in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", 64'(out_valid_v[0]), 64'd0);
        check("abort_fields", 64'({out_zero_v[0], out_ovf_v[0], out_c_v[0], out_v[0]}), 64'd0);
        check("abort_in_ready", 64'(in_ready_v[0]), 64'd1);
        rst = 1'b0;
        rose = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid_v[0]) rose = 1;
        end
        check("abort_no_result", 64'(rose), 64'd0);
        check("abort_idle", 64'(in_ready_v[0]), 64'd1);
        do_op(0, 32'd3, 32'd4, 1'b0, 0);

        for (int i = 0; i < 60; i++) begin
            do_op(i % 3, pick_operand(), pick_operand(), 1'($urandom), int'($urandom % 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_addsub.md
SEQ_ADDSUB -- requirements
Module: seq_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8: bits added per cycle; WIDTH % CHUNK == 0 and CHUNK >= 1 are required, violation is a compile-time error.
REQ-003 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands and mode are valid.
REQ-006 SHALL have port in_ready  output  1  block accepts a new operation.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid  output  1  result fields valid.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out  output  WIDTH  sum or difference, modulo 2^WIDTH.
REQ-013 SHALL have port out_c  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-014 SHALL have port out_overflow  output  1  two's-complement signed overflow.
REQ-015 SHALL have port out_zero  output  1  out == 0.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-017 SHALL, on an edge with in_valid && in_ready, latch a, b (inverted when sub=1) and sub, set chunk index 0, set carry-in = sub, and go to CALC.
REQ-018 SHALL, in each CALC cycle, add chunk index i of a and b plus carry register, write CHUNK result bits to out[i*CHUNK +: CHUNK], store carry, increment i.
REQ-019 SHALL go CALC -> DONE on the edge that processes chunk NCHUNK-1 (NCHUNK = WIDTH/CHUNK); out_valid therefore rises exactly NCHUNK edges after the accepting edge.
REQ-020 SHALL, on entering DONE, present out_c = final carry, out_overflow = (a[MSB] == b_eff[MSB]) && (out[MSB] != a[MSB]) using latched operands with b_eff = inverted b for sub, out_zero = (out == 0).
REQ-021 SHALL hold out, out_c, out_overflow, out_zero stable while out_valid && !out_ready.
REQ-022 SHALL go DONE -> IDLE on out_valid && out_ready; no new operation is accepted in that same cycle.
REQ-023 SHALL ignore a, b, sub, in_valid while not in IDLE.
REQ-024 SHALL support CHUNK == WIDTH (single CALC cycle) and CHUNK == 1 (bit-serial).
REQ-025 SHALL keep result fields holding their last values in IDLE and CALC; only out_valid qualifies them.

Reset
REQ-026 SHALL, while rst is high at a clock edge, set state IDLE, chunk index 0, carry 0, out 0, out_c 0, out_overflow 0, out_zero 0, out_valid 0; rst takes priority over every handshake.
REQ-027 SHALL abort any in-flight CALC or pending DONE on reset with no result emitted; in_ready is 1 in the first cycle after rst deasserts.

Structure
REQ-028 SHALL place the state enum (IDLE/CALC/DONE) and the op encoding (ADD=0, SUB=1) in shared package addsub_pkg.
REQ-029 SHALL instantiate one combinational sub-module add_chunk (CHUNK-bit a, b, cin -> CHUNK-bit sum, cout) for the per-cycle datapath.

Verification (WIDTH=32, CHUNK=8)
REQ-030 SHALL check add 0x7FFFFFFF + 0x00000001 -> out 0x80000000, out_c 0, out_overflow 1, out_zero 0, out_valid exactly 4 edges after accept.
REQ-031 SHALL check add 0xFFFFFFFF + 0x00000001 -> out 0x00000000, out_c 1, out_overflow 0, out_zero 1.
REQ-032 SHALL check sub 5 - 7 -> out 0xFFFFFFFE, out_c 0, out_overflow 0; and sub 0x80000000 - 1 -> out 0x7FFFFFFF, out_c 1, out_overflow 1.
REQ-033 SHALL check back-pressure: out_ready low 5 cycles in DONE -> outputs stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next edge.
REQ-034 SHALL check rst asserted after 2 CALC cycles -> out_valid never rises, all outputs 0, in_ready 1 after release, next op 3+4 -> 7.
REQ-035 SHALL repeat REQ-030 with CHUNK=32 (latency 1) and CHUNK=1 (latency 32).
